// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and load-extension helper for dmem_ctrl.
// Build option DMEM_INIT_CLEAR_EN adds the INIT (array clear) state.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef DMEM_INIT_CLEAR_EN
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} dmem_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} dmem_state_e;
`endif

    // Lane-select a little-endian word and sign/zero-extend to 32 bits.
    function automatic logic [31:0] dmem_load_ext(input logic [31:0] word,
                                                  input logic [1:0]  offset,
                                                  input logic [1:0]  size,
                                                  input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            SZ_WORD: r = word;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with per-lane write enables and a registered, enable-gated read port.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    we_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // NOTE: storage arrays get no reset; clearing them is the job of the write port.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we_i[l]) mem[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
        end
        if (re_i) rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding load/store data memory with byte/half/word lanes and
// configurable response latency. Build option DMEM_INIT_CLEAR_EN clears the array after reset.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_busy
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        store_q, store_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        req_ready_q, resp_valid_q;
`ifdef DMEM_INIT_CLEAR_EN
    logic [AW-1:0] clr_idx_q, clr_idx_d;
`endif

    logic          accept;
    logic          out_of_range;
    logic          misaligned;
    logic          req_err;
    logic [3:0]    lane_we;
    logic [31:0]   lane_wdata;
    logic [AW-1:0] arr_addr;
    logic [3:0]    arr_we;
    logic [31:0]   arr_wdata;
    logic          arr_re;
    logic [31:0]   arr_rdata;

    assign accept       = req_valid && req_ready_q;
    assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    assign misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign req_err      = out_of_range || misaligned || (req_size == 2'b11);

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                lane_we    = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_we    = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_wdata[15:0]}};
            end
            SZ_WORD: lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
    end

    // The read port is only enabled for a good load, so its register holds the word through RESP.
    always_comb begin
        arr_addr  = req_addr[AW+1:2];
        arr_we    = 4'b0000;
        arr_wdata = lane_wdata;
        arr_re    = 1'b0;
        if (accept && !req_err) begin
            if (req_we) arr_we = lane_we;
            else        arr_re = 1'b1;
        end
`ifdef DMEM_INIT_CLEAR_EN
        if (state_q == ST_INIT) begin
            arr_addr  = clr_idx_q;
            arr_we    = 4'b1111;
            arr_wdata = 32'h0;
        end
`endif
    end

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .addr_i  (arr_addr),
        .we_i    (arr_we),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        store_d = store_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
`ifdef DMEM_INIT_CLEAR_EN
        clr_idx_d = clr_idx_q;
`endif
        case (state_q)
`ifdef DMEM_INIT_CLEAR_EN
            ST_INIT: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
            end
`endif
            ST_IDLE: begin
                if (accept) begin
                    err_d   = req_err;
                    store_d = req_we;
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (resp_valid_q && resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
`ifdef DMEM_INIT_CLEAR_EN
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
`else
            state_q   <= ST_IDLE;
`endif
            cnt_q        <= 4'd0;
            err_q        <= 1'b0;
            store_q      <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
`ifdef DMEM_INIT_CLEAR_EN
            clr_idx_q    <= clr_idx_d;
`endif
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            store_q      <= store_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_valid_q && err_q;
    assign resp_rdata = (resp_valid_q && !err_q && !store_q) ?
                        dmem_load_ext(arr_rdata, off_q, size_q, uns_q) : 32'h0;

`ifdef DMEM_INIT_CLEAR_EN
    assign init_busy = (state_q == ST_INIT);
`else
    assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_dmem_ctrl;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    localparam int BOUND = 2000;
`ifdef DMEM_INIT_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        init_busy;

    int errors = 0;
    int checks = 0;

    dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .init_busy    (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: a byte-addressed memory plus a transaction-level view of
    // the single outstanding request (cycles since accept, response taken or not).
    logic [7:0]  m_mem   [DEPTH*4];
    bit          m_known [DEPTH*4];
    int          m_wait_left = 0;
    bit          m_pending = 1'b0;
    int          m_age = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    bit          m_rknown = 1'b1;

    task automatic model_accept();
        longint unsigned a;
        longint unsigned v;
        int n;
        a = longint'(req_addr);
        n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        v = 0;
        m_err    = (a / 4 >= DEPTH) || (req_size == 2'd3) || (a % n != 0);
        m_rknown = 1'b1;
        m_rdata  = 32'h0;
        if (!m_err) begin
            if (req_we) begin
                for (int i = 0; i < n; i++) begin
                    m_mem[a + i]   = req_wdata[8*i +: 8];
                    m_known[a + i] = 1'b1;
                end
            end else begin
                for (int i = 0; i < n; i++) begin
                    v = v | (longint'(m_mem[a + i]) << (8 * i));
                    m_rknown = m_rknown && m_known[a + i];
                end
                if (!req_unsigned && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
                m_rdata = v[31:0];
            end
        end
        m_pending = 1'b1;
        m_age     = 0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pending   = 1'b0;
            m_age       = 0;
            m_wait_left = CLEAR ? DEPTH : 1;
            if (CLEAR) begin
                for (int i = 0; i < DEPTH*4; i++) begin
                    m_mem[i]   = 8'h00;
                    m_known[i] = 1'b1;
                end
            end
        end else if (m_wait_left > 0) begin
            m_wait_left--;
        end else if (m_pending) begin
            if (m_age >= LAT - 1 && resp_ready) m_pending = 1'b0;
            else                                m_age++;
        end else if (req_valid) begin
            model_accept();
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = m_pending && (m_age >= LAT - 1);
        check("init_busy",  init_busy,  CLEAR && (m_wait_left > 0));
        check("req_ready",  req_ready,  !m_pending && (m_wait_left == 0));
        check("resp_valid", resp_valid, ev);
        check("resp_err",   resp_err,   ev && m_err);
        if (!ev || m_rknown) check("resp_rdata", resp_rdata, ev ? m_rdata : 32'h0);
    end

    // One request; stall < 0 randomizes resp_ready, else holds it low for 'stall' cycles.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int stall,
                          output logic [31:0] rd, output logic er);
        bit acc;
        bit got;
        int n;
        acc = 1'b0;
        got = 1'b0;
        rd  = 32'h0;
        er  = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        n = 0;
        while (!acc && n < BOUND) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1; n++;
        end
        check("accepted", acc, 1);
        n = 0;
        while (acc && !got && n < BOUND) begin
            resp_ready   = (stall < 0) ? ($urandom_range(0, 3) != 0) : (n >= stall);
            req_valid    = 1'($urandom_range(0, 1));
            req_we       = 1'($urandom_range(0, 1));
            req_addr     = $urandom_range(0, 255);
            req_size     = 2'($urandom_range(0, 3));
            req_wdata    = $urandom;
            @(negedge clk);
            if (resp_valid) begin
                rd  = resp_rdata;
                er  = resp_err;
                got = resp_ready;
            end
            @(posedge clk); #1; n++;
        end
        check("responded", got, 1);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        bit          acc;
        int          n;
        int          mode;
        logic [31:0] addr;

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

`ifdef DMEM_INIT_CLEAR_EN
        n = 0;
        while (init_busy && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        check("init_cycles", n, DEPTH);
        do_req(1'b0, 32'h3FC, 2'd2, 1'b0, 32'h0, -1, rd, er);
        check("cleared_3fc", rd, 32'h00000000);
`endif

        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom, -1, rd, er);

        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'h8899AABB, -1, rd, er);
        check("sw_rdata", rd, 32'h0);
        check("sw_err", er, 0);
        do_req(1'b0, 32'h11, 2'd0, 1'b0, 32'h0, -1, rd, er);
        check("lb_11", rd, 32'hFFFFFFAA);
        do_req(1'b0, 32'h11, 2'd0, 1'b1, 32'h0, -1, rd, er);
        check("lbu_11", rd, 32'h000000AA);
        do_req(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, -1, rd, er);
        check("lh_12", rd, 32'hFFFF8899);
        do_req(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, -1, rd, er);
        check("lhu_12", rd, 32'h00008899);
        do_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h0000005A, -1, rd, er);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, -1, rd, er);
        check("lw_10", rd, 32'h5A99AABB);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, rd, er);
        check("lw_stall", rd, 32'h5A99AABB);

        do_req(1'b1, 32'h20, 2'd2, 1'b0, 32'h11223344, -1, rd, er);
        do_req(1'b1, 32'h21, 2'd1, 1'b0, 32'h0000BEEF, -1, rd, er);
        check("sh_21_err", er, 1);
        check("sh_21_rdata", rd, 32'h0);
        do_req(1'b0, 32'h22, 2'd2, 1'b0, 32'h0, -1, rd, er);
        check("lw_22_err", er, 1);
        check("lw_22_rdata", rd, 32'h0);
        do_req(1'b0, 32'h400, 2'd2, 1'b0, 32'h0, -1, rd, er);
        check("lw_400_err", er, 1);
        check("lw_400_rdata", rd, 32'h0);
        do_req(1'b1, 32'h20, 2'd3, 1'b0, 32'hDEADBEEF, -1, rd, er);
        check("size11_err", er, 1);
        do_req(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, -1, rd, er);
        check("lw_20_unchanged", rd, 32'h11223344);

        // Store accepted, then reset lands while the response is still counting down.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
        acc = 1'b0;
        n = 0;
        while (!acc && n < BOUND) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1; n++;
        end
        check("abort_accepted", acc, 1);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        resp_ready = 1'b0;
        do_req(1'b0, 32'h30, 2'd2, 1'b0, 32'h0, -1, rd, er);
`ifdef DMEM_INIT_CLEAR_EN
        check("lw_30_after_reset", rd, 32'h00000000);
`else
        check("lw_30_after_reset", rd, 32'hCAFEF00D);
`endif

        for (int k = 0; k < 400; k++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0)      addr = $urandom;
            else if (mode == 1) addr = 32'(DEPTH * 4 + $urandom_range(0, 63));
            else                addr = $urandom_range(0, 255);
            do_req(1'($urandom_range(0, 1)), addr, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, -1, rd, er);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
